vending_ctrl: RTL and testbench
===============================

# vending_ctrl

Parametrised vending-machine controller for the lab datapath: loads a price table after reset, accumulates inserted coins into a credit register, and dispenses a selected item with change. It generalises the single-purchase vending block to `ITEMS` products and `W`-bit money, and adds proper credit retention, cancel/refund, overflow rejection and an optional stock tracker. It sits between the coin/keypad front-end and the dispense/change actuators.

## Interface
- `ITEMS`, 4: number of products (2..15); selection codes are 1..`ITEMS`.
- `W`, 8: width of prices, coins, credit and change.
- `STOCK_INIT`, 3: per-item stock loaded at reset (used only with `VEND_STOCK_EN`).
- `SW` (localparam): `$clog2(ITEMS+1)`, width of selection and product codes.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `load`  in  1  price-load strobe, honoured only in LOAD.
- `DI`  in  W  price data, written when `load` is high.
- `MI`  in  W  coin value inserted this cycle (0 = none).
- `sel`  in  SW  product selection (0 = none).
- `cancel`  in  1  refund request.
- `ready`  out  1  high in COLLECT.
- `vld`  out  1  one-cycle pulse qualifying `MO` and `PO`.
- `MO`  out  W  change/refund amount.
- `PO`  out  SW  dispensed product code (0 = no product).
- `sold_out`  out  ITEMS  per-item empty flags (present only with `VEND_STOCK_EN`).

## Operation
- Reset (`rst`=0 at the edge): state LOAD, load index 0, credit 0, all prices 0; `ready`=0, `vld`=0, `MO`=0, `PO`=0; stock = `STOCK_INIT` per item.
- LOAD: each cycle with `load`=1 writes `DI` to `price[idx]` and increments `idx`. After the `ITEMS`-th write, go to COLLECT. `MI`, `sel` and `cancel` are ignored.
- COLLECT: `sum = credit + MI` is computed at W+1 bits. Priority per cycle, evaluated in this order:
  1. `cancel`=1: `vld`=1, `PO`=0, `MO`=`sum` (saturated to W bits), credit=0. Cancel beats `sel`.
  2. `sum` > 2^W-1 (overflow): the coin is rejected. `vld`=1, `PO`=0, `MO`=`MI`; credit unchanged; `sel` ignored this cycle.
  3. `sel`=k with 1≤k≤`ITEMS`, `sum`≥`price[k-1]` and the item in stock: `vld`=1, `PO`=k, `MO`=`sum`−`price[k-1]`, credit=0, stock[k-1] decrements.
  4. `sel`=k with `sum`<price, `sel`>`ITEMS`, or the item sold out: no output; credit=`sum` (the coin is kept).
  5. Otherwise: credit=`sum`.
- `MO` and `PO` return to 0 on every cycle with `vld`=0.
- A zero price is legal: the item is dispensed and the whole `sum` is returned as change.

## Timing
- All outputs are registered. A decision taken from inputs sampled at edge n appears at `vld`/`MO`/`PO` after edge n, for exactly one cycle.
- `ready` rises in the cycle after the final price load.
- Back-to-back purchases are allowed on consecutive cycles; there is no busy state.
- Reset asserted mid-operation discards credit and prices with no refund pulse. The next cycle re-enters LOAD.
- Stock never wraps: at 0 the item is sold out, and the counter saturates.

## Configuration
- `VEND_STOCK_EN` defined: per-item stock counters (width `$clog2(STOCK_INIT+1)`), the `sold_out` port, and the sold-out rule in step 3.
- `VEND_STOCK_EN` undefined: the counters and the `sold_out` port are removed, and every item is always in stock.

## Test plan
- Load prices 10, 20, 30, 40; insert 5 then 15; `sel`=2 in the next cycle → `vld`=1, `PO`=2, `MO`=0; credit returns to 0.
- Credit 25; `sel`=3 → no `vld`, credit stays 25. Then insert 10 with `sel`=3 → `PO`=3, `MO`=5.
- Credit 250, `MI`=10 (W=8) → `vld`=1, `PO`=0, `MO`=10, credit stays 250. Then `cancel`=1 with `sel`=1 → `PO`=0, `MO`=250.
- With `VEND_STOCK_EN` and `STOCK_INIT`=3: four purchases of item 1 at price 10 with `MI`=10 → first three give `PO`=1; after the third, `sold_out[0]`=1; the fourth keeps credit 10.
- Pull `rst` low in the middle of loading and again with credit 30 → all outputs 0, `ready`=0; a fresh 4-price load is required before purchases.

Source files
------------

// File: rtl/vending_ctrl.sv
// Vending-machine controller: price-table load, coin credit, purchase with change, cancel/refund.
// Optional per-item stock tracking and the sold_out port are enabled with the VEND_STOCK_EN macro.
module vending_ctrl #(
    parameter int ITEMS      = 4,
    parameter int W          = 8,
    parameter int STOCK_INIT = 3,
    localparam int SW        = $clog2(ITEMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  DI,
    input  logic [W-1:0]  MI,
    input  logic [SW-1:0] sel,
    input  logic          cancel,
    output logic          ready,
    output logic          vld,
    output logic [W-1:0]  MO,
    output logic [SW-1:0] PO
`ifdef VEND_STOCK_EN
    ,
    output logic [ITEMS-1:0] sold_out
`endif
);

    // Output handshake: vld is a one-cycle pulse qualifying MO/PO; both are 0 whenever vld is 0.
    // There is no back-pressure, so the actuator side must accept every pulse it sees.

    typedef enum logic {S_LOAD, S_COLLECT} state_t;

    state_t        state;
    logic [SW-1:0] idx;
    logic [W-1:0]  credit;
    logic [W-1:0]  price [ITEMS];

    logic [W:0]    sum;
    logic [W-1:0]  sum_sat;
    logic [W-1:0]  change;
    logic [W-1:0]  sel_price;
    logic          sel_hit;
    logic          sel_stock;

`ifdef VEND_STOCK_EN
    localparam int ST_W = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);
    logic [ST_W-1:0] stock [ITEMS];

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < ITEMS; i++) begin
            sold_out[i] = (stock[i] == '0);
        end
    end
`endif

    assign sum     = {1'b0, credit} + {1'b0, MI};
    assign sum_sat = sum[W] ? '1 : sum[W-1:0];
    assign change  = sum[W-1:0] - sel_price;

    // Decode the selection by comparison so codes 0 and >ITEMS never index the table.
    always_comb begin
        sel_price = '0;
        sel_hit   = 1'b0;
        sel_stock = 1'b1;
        for (int i = 0; i < ITEMS; i++) begin
            if (sel == SW'(i + 1)) begin
                sel_hit   = 1'b1;
                sel_price = price[i];
`ifdef VEND_STOCK_EN
                sel_stock = (stock[i] != '0);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_LOAD;
            idx    <= '0;
            credit <= '0;
            ready  <= 1'b0;
            vld    <= 1'b0;
            MO     <= '0;
            PO     <= '0;
            for (int i = 0; i < ITEMS; i++) begin
                price[i] <= '0;
`ifdef VEND_STOCK_EN
                stock[i] <= ST_W'(STOCK_INIT);
`endif
            end
        end else begin
            vld <= 1'b0;
            MO  <= '0;
            PO  <= '0;
            case (state)
                S_LOAD: begin
                    if (load) begin
                        for (int i = 0; i < ITEMS; i++) begin
                            if (idx == SW'(i)) price[i] <= DI;
                        end
                        if (idx == SW'(ITEMS - 1)) begin
                            idx   <= '0;
                            state <= S_COLLECT;
                            ready <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (cancel) begin
                        vld    <= 1'b1;
                        MO     <= sum_sat;
                        credit <= '0;
                    end else if (sum[W]) begin
                        // Coin would overflow the credit register: hand it straight back.
                        vld <= 1'b1;
                        MO  <= MI;
                    end else if (sel_hit && sel_stock && (sum >= {1'b0, sel_price})) begin
                        vld    <= 1'b1;
                        PO     <= sel;
                        MO     <= change;
                        credit <= '0;
`ifdef VEND_STOCK_EN
                        for (int i = 0; i < ITEMS; i++) begin
                            if (sel == SW'(i + 1)) stock[i] <= stock[i] - 1'b1;
                        end
`endif
                    end else begin
                        credit <= sum[W-1:0];
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl: expected pulses are queued by the drivers and
// checked by an independent monitor on the falling edge.
module tb_vending_ctrl;
    localparam int ITEMS = 4;
    localparam int W     = 8;
    localparam int SW    = $clog2(ITEMS + 1);

    logic          clk;
    logic          rst;
    logic          load;
    logic [W-1:0]  DI;
    logic [W-1:0]  MI;
    logic [SW-1:0] sel;
    logic          cancel;
    logic          ready;
    logic          vld;
    logic [W-1:0]  MO;
    logic [SW-1:0] PO;
`ifdef VEND_STOCK_EN
    logic [ITEMS-1:0] sold_out;
`endif

    vending_ctrl #(.ITEMS(ITEMS), .W(W), .STOCK_INIT(3)) dut (
        .clk(clk), .rst(rst), .load(load), .DI(DI), .MI(MI), .sel(sel),
        .cancel(cancel), .ready(ready), .vld(vld), .MO(MO), .PO(PO)
`ifdef VEND_STOCK_EN
        , .sold_out(sold_out)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    logic mon_en = 1'b0;
    logic [W+SW-1:0] exp_q[$];

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic clear_inputs();
        load = 1'b0; DI = '0; MI = '0; sel = '0; cancel = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, 32'(ready), 32'd0);
        check_eq({tag, "_vld"},   32'(vld),   32'd0);
        check_eq({tag, "_MO"},    32'(MO),    32'd0);
        check_eq({tag, "_PO"},    32'(PO),    32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check_idle(tag);
        rst = 1'b1;
    endtask

    // Loads prices while driving junk on the COLLECT inputs, which LOAD must ignore.
    task automatic load_prices(input logic [W-1:0] p0, input logic [W-1:0] p1,
                               input logic [W-1:0] p2, input logic [W-1:0] p3);
        logic [W-1:0] p [ITEMS];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int i = 0; i < ITEMS; i++) begin
            load = 1'b1; DI = p[i]; MI = 8'd7; sel = 3'd1; cancel = 1'b1;
            @(posedge clk);
            #1;
            if (i == ITEMS - 2) check_eq("ready_before_last_load", 32'(ready), 32'd0);
        end
        check_eq("ready_after_load", 32'(ready), 32'd1);
        clear_inputs();
    endtask

    // Drives one COLLECT cycle; a pulse expected from this cycle is queued first.
    task automatic apply(input logic [W-1:0] mi, input logic [SW-1:0] s, input logic c,
                         input logic ev, input logic [W-1:0] emo, input logic [SW-1:0] epo);
        MI = mi; sel = s; cancel = c;
        if (ev) exp_q.push_back({emo, epo});
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (vld) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: got MO=%0d PO=%0d, expected no pulse", MO, PO);
                end else begin
                    logic [W+SW-1:0] e;
                    e = exp_q.pop_front();
                    if ({MO, PO} !== e) begin
                        n_err++;
                        $display("FAIL pulse: got MO=%0d PO=%0d, expected MO=%0d PO=%0d",
                                 MO, PO, e[W+SW-1:SW], e[SW-1:0]);
                    end
                end
            end else if (MO !== '0 || PO !== '0) begin
                n_err++;
                $display("FAIL idle_outputs: got MO=%0d PO=%0d, expected 0 0", MO, PO);
            end
        end
    end

    // stimulus
    initial begin
        rst = 1'b0;
        clear_inputs();
        do_reset("reset");
        load_prices(8'd10, 8'd20, 8'd30, 8'd40);

        apply(8'd5,  3'd0, 1'b0, 1'b0, 8'd0, 3'd0);
        apply(8'd15, 3'd0, 1'b0, 1'b0, 8'd0, 3'd0);
        apply(8'd0,  3'd2, 1'b0, 1'b1, 8'd0, 3'd2);   // exact price, credit back to 0

        apply(8'd25, 3'd0, 1'b0, 1'b0, 8'd0, 3'd0);
        apply(8'd0,  3'd3, 1'b0, 1'b0, 8'd0, 3'd0);   // short by 5, credit kept
        apply(8'd10, 3'd3, 1'b0, 1'b1, 8'd5, 3'd3);

        apply(8'd250, 3'd0, 1'b0, 1'b0, 8'd0, 3'd0);
        apply(8'd10,  3'd0, 1'b0, 1'b1, 8'd10, 3'd0); // overflow rejects coin
        apply(8'd10,  3'd1, 1'b0, 1'b1, 8'd10, 3'd0); // overflow beats sel
        apply(8'd0,   3'd1, 1'b1, 1'b1, 8'd250, 3'd0);// cancel beats sel

        apply(8'd250, 3'd0, 1'b0, 1'b0, 8'd0, 3'd0);
        apply(8'd10,  3'd0, 1'b1, 1'b1, 8'd255, 3'd0);// cancel saturates 260 to 255

`ifdef VEND_STOCK_EN
        check_eq("sold_out_init", 32'(sold_out), 32'd0);
        for (int i = 0; i < 3; i++) apply(8'd10, 3'd1, 1'b0, 1'b1, 8'd0, 3'd1);
        check_eq("sold_out_item1", 32'(sold_out), 32'd1);
        apply(8'd10, 3'd1, 1'b0, 1'b0, 8'd0, 3'd0);   // sold out, coin kept
        apply(8'd0,  3'd0, 1'b1, 1'b1, 8'd10, 3'd0);
`else
        for (int i = 0; i < 4; i++) apply(8'd10, 3'd1, 1'b0, 1'b1, 8'd0, 3'd1);
`endif

        apply(8'd10, 3'd5, 1'b0, 1'b0, 8'd0, 3'd0);   // code above ITEMS
        apply(8'd0,  3'd7, 1'b0, 1'b0, 8'd0, 3'd0);
        apply(8'd0,  3'd0, 1'b1, 1'b1, 8'd10, 3'd0);

        apply(8'd20, 3'd2, 1'b0, 1'b1, 8'd0, 3'd2);   // back-to-back purchases
        apply(8'd45, 3'd4, 1'b0, 1'b1, 8'd5, 3'd4);

        apply(8'd30, 3'd0, 1'b0, 1'b0, 8'd0, 3'd0);
        do_reset("reset_with_credit");                 // no refund pulse allowed

        load = 1'b1; DI = 8'd99;
        repeat (2) @(posedge clk);
        #1;
        clear_inputs();
        do_reset("reset_mid_load");
        apply(8'd50, 3'd1, 1'b0, 1'b0, 8'd0, 3'd0);   // still in LOAD: ignored
        check_eq("ready_unloaded", 32'(ready), 32'd0);

        load_prices(8'd0, 8'd20, 8'd30, 8'd40);
        apply(8'd0, 3'd0, 1'b1, 1'b1, 8'd0, 3'd0);    // credit was discarded
        apply(8'd7, 3'd1, 1'b0, 1'b1, 8'd7, 3'd1);    // zero price returns whole sum
        apply(8'd0, 3'd1, 1'b0, 1'b1, 8'd0, 3'd1);
        apply(8'd19, 3'd2, 1'b0, 1'b0, 8'd0, 3'd0);
        apply(8'd1,  3'd2, 1'b0, 1'b1, 8'd0, 3'd2);

        repeat (3) @(posedge clk);
        #1;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
